// File: rtl/fir_pkg.sv
// Shared FIR stream constants: default data width, FIFO depth and stream beat width.
// A beat is one data word plus its tlast marker.
package fir_pkg;
  localparam int FIR_DATA_W  = 32;
  localparam int FIR_DEPTH   = 8;
  localparam int FIR_TLAST_W = 1;
  localparam int FIR_BEAT_W  = FIR_DATA_W + FIR_TLAST_W;

  function automatic int fir_beat_w(input int data_w);
    return data_w + FIR_TLAST_W;
  endfunction
endpackage

// File: rtl/fir_sm_fifo_mem.sv
// FIFO storage: register array with one synchronous write port and one async read port.
// Contents are deliberately left unreset so that reset only clears the pointers.
module fir_sm_fifo_mem #(
  parameter int W     = 33,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/fir_sm_fifo.sv
// First-word-fall-through FIFO between the FIR sm stream and the Wishbone stream-read path.
// Optional FIR_SM_FIFO_STATS_EN adds frame_cnt and max_level statistics outputs.
module fir_sm_fifo import fir_pkg::*; #(
  parameter int DATA_W  = FIR_DATA_W,
  parameter int DEPTH   = FIR_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              flush,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic [LVL_W-1:0]  level
`ifdef FIR_SM_FIFO_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [LVL_W-1:0]  max_level
`endif
);
  localparam int BEAT_W = (DATA_W == FIR_DATA_W) ? FIR_BEAT_W : fir_beat_w(DATA_W);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [BEAT_W-1:0] rd_beat;
  logic              push, pop;

  // Ready is a pure function of the registered level, gated only by reset.
  assign s_tready = axis_rst_n & (level_q != LVL_W'(DEPTH));
  assign m_tvalid = (level_q != '0);
  assign push     = s_tvalid & s_tready;
  assign pop      = m_tvalid & m_tready;
  assign level    = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  fir_sm_fifo_mem #(
    .W     (BEAT_W),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (axis_clk),
    .we    (push & ~flush),
    .waddr (wr_ptr_q),
    .wdata ({s_tlast, s_tdata}),
    .raddr (rd_ptr_q),
    .rdata (rd_beat)
  );

  // Mask the head when empty so stale storage never leaks out (including during reset).
  assign m_tdata = m_tvalid ? rd_beat[DATA_W-1:0] : '0;
  assign m_tlast = m_tvalid & rd_beat[BEAT_W-1];

`ifdef FIR_SM_FIFO_STATS_EN
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [LVL_W-1:0] max_level_q, max_level_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    max_level_d = max_level_q;
    if (flush) begin
      frame_cnt_d = '0;
      max_level_d = '0;
    end else begin
      if (pop && m_tlast) frame_cnt_d = frame_cnt_q + 16'd1;
      if (level_d > max_level_q) max_level_d = level_d;
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      frame_cnt_q <= '0;
      max_level_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      max_level_q <= max_level_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign max_level = max_level_q;
`endif
endmodule

// File: doc/fir_sm_fifo.md
FIR_SM_FIFO -- requirements
Module: fir_sm_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32: stream data width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: entries, power of two, 2..64.
REQ-003 SHALL have port axis_clk, in, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port axis_rst_n, in, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port flush, in, 1: synchronous soft clear of contents.
REQ-006 SHALL have port s_tvalid, in, 1: upstream (FIR sm_tvalid) word valid.
REQ-007 SHALL have port s_tready, out, 1: FIFO can accept a word.
REQ-008 SHALL have port s_tdata, in, DATA_W: upstream word.
REQ-009 SHALL have port s_tlast, in, 1: upstream end-of-frame marker.
REQ-010 SHALL have port m_tvalid, out, 1: head word valid to the Wishbone bridge stream-read path.
REQ-011 SHALL have port m_tready, in, 1: downstream accepts the head word.
REQ-012 SHALL have port m_tdata, out, DATA_W: head word.
REQ-013 SHALL have port m_tlast, out, 1: tlast stored with the head word.
REQ-014 SHALL have port level, out, $clog2(DEPTH)+1: current occupancy, 0..DEPTH.

Function
REQ-015 SHALL push when s_tvalid&s_tready, storing {s_tlast,s_tdata}; pop when m_tvalid&m_tready.
REQ-016 SHALL drive s_tready = (level != DEPTH) combinationally from registered state only; no dependence on m_tready.
REQ-017 SHALL drive m_tvalid = (level != 0); m_tdata/m_tlast show the head entry (first-word-fall-through).
REQ-018 SHALL make a word pushed into an empty FIFO visible on m_tvalid in the following cycle (1-cycle latency).
REQ-019 SHALL, on simultaneous push and pop, keep level unchanged; when full, pop frees no slot in the same cycle (s_tready stays 0 that cycle).
REQ-020 SHALL, when empty, ignore m_tready; when full, drop nothing since s_tready=0 blocks the push.
REQ-021 SHALL use read/write pointers of $clog2(DEPTH) bits wrapping DEPTH-1 -> 0 modulo DEPTH.
REQ-022 SHALL, when flush=1, set level, pointers to 0 next cycle; a push or pop in that same cycle is discarded.
REQ-023 SHALL hold m_tdata/m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-024 SHALL not alter data storage contents on reset; only pointers/level are cleared.

Reset
REQ-025 SHALL, while axis_rst_n=0, force level=0, pointers=0, s_tready=0, m_tvalid=0, m_tdata=0 (masked), m_tlast=0.
REQ-026 SHALL assert s_tready=1 in the first cycle after axis_rst_n deasserts; reset mid-transfer discards all contents.

Configuration
REQ-027 SHALL, with FIR_SM_FIFO_STATS_EN defined, add outputs frame_cnt (16 bits, increments on each popped word with m_tlast=1, wraps at 0xFFFF->0) and max_level (width of level, holds peak level since reset/flush); both cleared by reset and flush.
REQ-028 SHALL, without FIR_SM_FIFO_STATS_EN, omit those ports and their logic entirely.

Structure
REQ-029 SHALL take DATA_W default, DEPTH default and the stream beat width constant from shared package fir_pkg.
REQ-030 SHALL place storage in sub-module fir_sm_fifo_mem (register array, 1 write port, 1 async read port).

Verification
REQ-031 SHALL cover: reset release, push 0x11 -> m_tvalid=1 next cycle, m_tdata=0x11, level=1.
REQ-032 SHALL cover: m_tready=0, push 8 words 1..8 -> s_tready=0, level=8; pop one -> s_tready=1 the next cycle, head=2.
REQ-033 SHALL cover: continuous push/pop at level 3 for 20 cycles -> level stays 3, output order equals input order across pointer wrap.
REQ-034 SHALL cover: flush asserted with push of 0xAA at level 5 -> level=0 next cycle, 0xAA never emitted.
REQ-035 SHALL cover: axis_rst_n pulled low at level 4 -> m_tvalid=0 immediately (async), level=0.
REQ-036 SHALL cover (STATS_EN): three frames of 4 words, last flagged -> frame_cnt=3, max_level equals peak occupancy driven.
